// File: rtl/cpu_pkg.sv
// Purpose : shared CPU constants (datapath widths, zero register, write-back select codes).
// Latency : n/a (declarations only).
// Backpressure: n/a.
package cpu_pkg;

  // Default datapath widths; modules expose their own parameters that default to these.
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  // Register index that always reads as zero and ignores writes.
  localparam int REG_ZERO = 0;

  // MemtoReg select encodings shared by control, the write-back mux and benches.
  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LIMM = 2'b01,
    WB_PC4  = 2'b10,
    WB_MEM  = 2'b11
  } wb_sel_e;

endpackage

// File: rtl/reg_file_wb_if.sv
// Purpose : bundle of register-file write/read/debug signals between the CPU core and reg_file_wb.
// Latency : n/a (wires only).
// Backpressure: none; the register file accepts a write every cycle.
// master modport = CPU side (drives indices, RegWr, busW); slave = register file (drives read data).
interface reg_file_wb_if #(
  parameter int DATA_W = cpu_pkg::DEF_DATA_W,
  parameter int ADDR_W = cpu_pkg::DEF_ADDR_W,
  parameter int CNT_W  = 16
);

  logic              RegWr;
  logic [ADDR_W-1:0] Rw;
  logic [DATA_W-1:0] busW;
  logic [ADDR_W-1:0] Ra;
  logic [ADDR_W-1:0] Rb;
  logic [DATA_W-1:0] busA;
  logic [DATA_W-1:0] busB;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;
  logic [CNT_W-1:0]  wr_count;

  modport master (
    output RegWr, Rw, busW, Ra, Rb, dbg_addr,
    input  busA, busB, dbg_data, wr_count
  );

  modport slave (
    input  RegWr, Rw, busW, Ra, Rb, dbg_addr,
    output busA, busB, dbg_data, wr_count
  );

endinterface

// File: rtl/reg_file_wb_rf_read_port.sv
// Purpose : one combinational register-file read port with zero-register check and optional write forwarding.
// Latency : 0 cycles (pure combinational).
// Backpressure: none.
// Ports: rst (suppresses forwarding), rd_idx/stored (index and array word at that index),
//        wr_en/wr_idx/wr_data (write presented this cycle), rd_data (port output).
module rf_read_port
  import cpu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int BYPASS = 1
) (
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_idx,
  input  logic [DATA_W-1:0] stored,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);

  logic fwd;

  always_comb begin
    // Forward only a write that will actually commit at the coming edge:
    // not during reset, and never for the zero register.
    fwd = (BYPASS != 0) && !rst && wr_en &&
          (wr_idx != ADDR_W'(REG_ZERO)) && (wr_idx == rd_idx);

    rd_data = stored;
    if (rd_idx == ADDR_W'(REG_ZERO)) begin
      rd_data = '0;
    end else if (fwd) begin
      rd_data = wr_data;
    end
  end

endmodule

// File: rtl/reg_file_wb.sv
// Purpose : architectural register file fed by the write-back bus; 2 combinational read ports, 1 write port.
// Latency : reads 0 cycles (optionally forwarding busW); writes commit on the edge; dbg_data 1 cycle.
// Backpressure: none; one write accepted every cycle.
// Ports: clk, rst (sync, active-high); rf = slave view of reg_file_wb_if carrying
//        RegWr/Rw/busW (write), Ra/Rb -> busA/busB (reads), dbg_addr -> dbg_data, wr_count.
module reg_file_wb
  import cpu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int BYPASS = 1,
  parameter int CNT_W  = 16
) (
  input  logic         clk,
  input  logic         rst,
  reg_file_wb_if.slave rf
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [CNT_W-1:0]  wr_count_q, wr_count_d;
  logic [DATA_W-1:0] dbg_data_q, dbg_data_d;
  logic              commit;
  logic [DATA_W-1:0] bus_a, bus_b;

  always_comb begin
    // A write to the zero register is dropped entirely, so entry 0 keeps its
    // reset value forever and wr_count only counts writes that landed.
    commit     = rf.RegWr && (rf.Rw != ADDR_W'(REG_ZERO));
    regs_d     = regs_q;
    wr_count_d = wr_count_q;
    // Debug sees the array as it was before this edge's write.
    dbg_data_d = regs_q[rf.dbg_addr];
    if (commit) begin
      regs_d[rf.Rw] = rf.busW;
      wr_count_d    = wr_count_q + CNT_W'(1);
    end
  end

  // Reset wins over any write presented in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      wr_count_q <= '0;
      dbg_data_q <= '0;
    end else begin
      regs_q     <= regs_d;
      wr_count_q <= wr_count_d;
      dbg_data_q <= dbg_data_d;
    end
  end

  rf_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .BYPASS (BYPASS)
  ) u_rd_a (
    .rst     (rst),
    .rd_idx  (rf.Ra),
    .stored  (regs_q[rf.Ra]),
    .wr_en   (rf.RegWr),
    .wr_idx  (rf.Rw),
    .wr_data (rf.busW),
    .rd_data (bus_a)
  );

  rf_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .BYPASS (BYPASS)
  ) u_rd_b (
    .rst     (rst),
    .rd_idx  (rf.Rb),
    .stored  (regs_q[rf.Rb]),
    .wr_en   (rf.RegWr),
    .wr_idx  (rf.Rw),
    .wr_data (rf.busW),
    .rd_data (bus_b)
  );

  assign rf.busA     = bus_a;
  assign rf.busB     = bus_b;
  assign rf.dbg_data = dbg_data_q;
  assign rf.wr_count = wr_count_q;

endmodule

// File: tb/tb_reg_file_wb.sv
// Purpose : self-checking bench for reg_file_wb; one forwarding instance (4-bit counter) and one
//           non-forwarding instance (16-bit counter) share the same stimulus.
// Latency : n/a.
// Backpressure: n/a.
module tb_reg_file_wb;

  logic        clk;
  logic        rst;
  logic        regwr;
  logic [4:0]  rw, ra, rb, dbg;
  logic [31:0] busw;

  int total = 0;
  int bad   = 0;

  // Reference state: plain array of register contents, write count, debug register.
  logic [31:0] m_regs [32];
  logic [31:0] m_cnt;
  logic [31:0] m_dbg;

  reg_file_wb_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(4))  if_b1 ();
  reg_file_wb_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(16)) if_b0 ();

  assign if_b1.RegWr = regwr;  assign if_b0.RegWr = regwr;
  assign if_b1.Rw    = rw;     assign if_b0.Rw    = rw;
  assign if_b1.busW  = busw;   assign if_b0.busW  = busw;
  assign if_b1.Ra    = ra;     assign if_b0.Ra    = ra;
  assign if_b1.Rb    = rb;     assign if_b0.Rb    = rb;
  assign if_b1.dbg_addr = dbg; assign if_b0.dbg_addr = dbg;

  reg_file_wb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1), .CNT_W(4)) dut_b1 (
    .clk (clk), .rst (rst), .rf (if_b1.slave)
  );

  reg_file_wb #(.DATA_W(32), .ADDR_W(5), .BYPASS(0), .CNT_W(16)) dut_b0 (
    .clk (clk), .rst (rst), .rf (if_b0.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Expected read value straight from the rules: zero register reads 0, a forwarding
  // port returns a committing write's data, otherwise the stored word.
  function automatic logic [31:0] exp_rd(input logic [4:0] idx, input bit byp);
    if (idx == 5'd0) return '0;
    if (byp && !rst && regwr && rw != 5'd0 && idx == rw) return busw;
    return m_regs[idx];
  endfunction

  task automatic check_model(input string tag);
    check({tag, ".busA_byp"}, if_b1.busA, exp_rd(ra, 1'b1));
    check({tag, ".busB_byp"}, if_b1.busB, exp_rd(rb, 1'b1));
    check({tag, ".busA_nob"}, if_b0.busA, exp_rd(ra, 1'b0));
    check({tag, ".busB_nob"}, if_b0.busB, exp_rd(rb, 1'b0));
    check({tag, ".dbg_byp"},  if_b1.dbg_data, m_dbg);
    check({tag, ".dbg_nob"},  if_b0.dbg_data, m_dbg);
    check({tag, ".cnt4"},     if_b1.wr_count, {60'd0, m_cnt[3:0]});
    check({tag, ".cnt16"},    if_b0.wr_count, {48'd0, m_cnt[15:0]});
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  // Advance one edge and apply the same edge to the reference state.
  task automatic commit_edge();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_cnt = '0;
      m_dbg = '0;
    end else begin
      m_dbg = m_regs[dbg];
      if (regwr && rw != 5'd0) begin
        m_regs[rw] = busw;
        m_cnt      = m_cnt + 1;
      end
    end
    #1;
  endtask

  task automatic step(input string tag);
    settle();
    check_model(tag);
    commit_edge();
  endtask

  task automatic drive(input logic r, input logic w, input logic [4:0] d_rw,
                       input logic [31:0] d_w, input logic [4:0] d_ra, input logic [4:0] d_rb);
    rst = r; regwr = w; rw = d_rw; busw = d_w; ra = d_ra; rb = d_rb;
  endtask

  typedef struct {
    logic        r;
    logic        w;
    logic [4:0]  rw;
    logic [31:0] wd;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [31:0] a1, b1, a0, b0;
    int          cnt;
  } vec_t;

  vec_t vecs [6];
  logic [31:0] last17;

  initial begin
    // Directed vectors; expectations are values seen before each row's edge.
    vecs[0] = '{1'b0, 1'b1, 5'd3, 32'hDEADBEEF, 5'd3, 5'd3, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0, 32'h0, 0};
    vecs[1] = '{1'b0, 1'b0, 5'd0, 32'h0,        5'd3, 5'd0, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h0, 1};
    vecs[2] = '{1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd3, 32'h0, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 1};
    vecs[3] = '{1'b0, 1'b1, 5'd7, 32'h11,       5'd7, 5'd7, 32'h11, 32'h11, 32'h0, 32'h0, 1};
    vecs[4] = '{1'b0, 1'b1, 5'd7, 32'h22,       5'd7, 5'd7, 32'h22, 32'h22, 32'h11, 32'h11, 2};
    vecs[5] = '{1'b0, 1'b0, 5'd0, 32'h0,        5'd7, 5'd3, 32'h22, 32'hDEADBEEF, 32'h22, 32'hDEADBEEF, 3};

    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    dbg = 5'd0;
    @(posedge clk);
    @(posedge clk);
    #1;
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_cnt = '0;
    m_dbg = '0;

    // Reset state.
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd31);
    dbg = 5'd5;
    settle();
    check("reset.busA", if_b1.busA, 32'h0);
    check("reset.cnt",  if_b0.wr_count, 16'h0);
    check("reset.dbg",  if_b1.dbg_data, 32'h0);
    check_model("reset");
    commit_edge();

    // Table-driven directed vectors.
    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].r, vecs[i].w, vecs[i].rw, vecs[i].wd, vecs[i].ra, vecs[i].rb);
      settle();
      check($sformatf("vec%0d.a_byp", i), if_b1.busA, vecs[i].a1);
      check($sformatf("vec%0d.b_byp", i), if_b1.busB, vecs[i].b1);
      check($sformatf("vec%0d.a_nob", i), if_b0.busA, vecs[i].a0);
      check($sformatf("vec%0d.b_nob", i), if_b0.busB, vecs[i].b0);
      check($sformatf("vec%0d.cnt",   i), if_b0.wr_count, vecs[i].cnt);
      check_model($sformatf("vec%0d", i));
      commit_edge();
    end

    // Reset clears previously written contents; reads during reset see stored data.
    drive(1'b0, 1'b1, 5'd5, 32'h1234, 5'd0, 5'd0);
    step("preload5");
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
    settle();
    check("rst_hold.busA", if_b1.busA, 32'h1234);
    check_model("rst_hold");
    commit_edge();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
    dbg = 5'd5;
    settle();
    check("after_rst.busA", if_b1.busA, 32'h0);
    check("after_rst.cnt",  if_b0.wr_count, 16'h0);
    check("after_rst.dbg",  if_b0.dbg_data, 32'h0);
    check_model("after_rst");
    commit_edge();

    // Write colliding with reset is lost and forwarding is suppressed.
    drive(1'b1, 1'b1, 5'd9, 32'hAA, 5'd9, 5'd9);
    settle();
    check("collide.busA_byp", if_b1.busA, 32'h0);
    check_model("collide");
    commit_edge();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
    settle();
    check("collide_after.busA", if_b1.busA, 32'h0);
    check("collide_after.cnt",  if_b1.wr_count, 4'h0);
    check_model("collide_after");
    commit_edge();

    // 17 committed writes wrap the 4-bit counter to 1.
    last17 = '0;
    for (int i = 1; i <= 17; i++) begin
      drive(1'b0, 1'b1, 5'(i), $urandom, 5'(i), 5'($urandom_range(0, 31)));
      if (i == 17) last17 = busw;
      step("wrap");
    end
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd17, 5'd1);
    dbg = 5'd17;
    settle();
    check("wrap.cnt4",  if_b1.wr_count, 4'd1);
    check("wrap.cnt16", if_b0.wr_count, 16'd17);
    commit_edge();
    settle();
    check("wrap.dbg_byp", if_b1.dbg_data, last17);
    check("wrap.dbg_nob", if_b0.dbg_data, last17);
    commit_edge();

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      rst   = ($urandom_range(0, 99) < 3);
      regwr = ($urandom_range(0, 3) != 0);
      rw    = 5'($urandom_range(0, 31));
      busw  = $urandom;
      ra    = ($urandom_range(0, 2) == 0) ? rw : 5'($urandom_range(0, 31));
      rb    = ($urandom_range(0, 2) == 0) ? rw : 5'($urandom_range(0, 31));
      dbg   = 5'($urandom_range(0, 31));
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_file_wb.md
Name: reg_file_wb

Overview:
- Architectural register file that consumes the write-back bus produced by the 4:1 write-back select (MemtoReg mux) of the single-cycle CPU.
- Provides two combinational read ports (busA, busB) to the ALU/operand stage and one synchronous write port driven by busW.
- Register 0 is hardwired to zero.
- A debug read port and a retired-write counter support bench and board-level inspection.

Parameters:
- DATA_W, 32, width of each register and of busW/busA/busB.
- ADDR_W, 5, register index width; register count is 2**ADDR_W.
- BYPASS, 1, 1 = write-to-read forwarding in the same cycle; 0 = reads return the pre-write value.
- CNT_W, 16, width of the write counter.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- RegWr  input  1  write enable from control.
- Rw  input  ADDR_W  destination register index.
- busW  input  DATA_W  write-back data from the MemtoReg select.
- Ra  input  ADDR_W  read port A index.
- Rb  input  ADDR_W  read port B index.
- busA  output  DATA_W  read port A data, combinational.
- busB  output  DATA_W  read port B data, combinational.
- dbg_addr  input  ADDR_W  debug read index.
- dbg_data  output  DATA_W  debug read data, registered, 1-cycle latency.
- wr_count  output  CNT_W  number of committed writes since reset.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst). Sampled on the rising edge of clk only.
- On a clk edge with rst=1: all registers become 0, dbg_data becomes 0, wr_count becomes 0. rst overrides any concurrent RegWr.
- Write commit: at a clk edge with rst=0, RegWr=1 and Rw!=0, reg[Rw] <= busW and wr_count increments by 1.
- Writes to Rw=0 are discarded and do not increment wr_count.
- RegWr=0 leaves all state unchanged.
- wr_count wraps modulo 2**CNT_W with no saturation.
- Read ports: busA = reg[Ra] and busB = reg[Rb], purely combinational, zero latency. Ra=0 or Rb=0 always yields 0.
- BYPASS=1: if RegWr=1, Rw!=0 and Ra==Rw, busA = busW in the same cycle. The same rule applies to Rb and busB. Both ports may forward at once.
- BYPASS=0: a read of a register being written returns the old value until the edge, then the new value.
- Forwarding is suppressed while rst=1, so reads during reset return stored contents, not busW.
- Debug port: dbg_data <= reg[dbg_addr] on every edge with rst=0. The value reflects stored state before that edge's write (no bypass).
- Reset mid-operation: a write presented in the same cycle as rst=1 is lost. The first write after rst deasserts commits normally.
- No X propagation: all state has a defined reset value. Index widths are exact, so no out-of-range indices exist.

Decomposition:
- Shared package cpu_pkg holds:
  - DATA_W and ADDR_W defaults.
  - Constant REG_ZERO = 0.
  - MemtoReg select encodings WB_ALU=2'b00, WB_LIMM=2'b01, WB_PC4=2'b10, WB_MEM=2'b11, so the control unit, the write-back mux and the bench share them.
- One natural sub-module, rf_read_port: one index in, one data out, containing the zero-check and the optional bypass compare. It is instantiated twice, for A and B.
- The storage array and wr_count stay in the top module.

Test Plan:
- Reset: preload reg[5]=0x1234 via a write, assert rst for 1 cycle -> busA with Ra=5 reads 0x00000000, wr_count=0, dbg_data=0 after the next edge.
- Basic write/read: RegWr=1, Rw=3, busW=0xDEADBEEF for one edge, then Ra=3, Rb=3 -> busA=busB=0xDEADBEEF, wr_count=1.
- Zero register: RegWr=1, Rw=0, busW=0xFFFFFFFF -> busA with Ra=0 stays 0, wr_count unchanged.
- Bypass, with reg[7]=0x11: same cycle RegWr=1, Rw=7, busW=0x22, Ra=7, Rb=7.
  - BYPASS=1 -> busA=busB=0x22 before the edge.
  - BYPASS=0 -> 0x11 before the edge and 0x22 after it.
- Reset collision: rst=1 and RegWr=1, Rw=9, busW=0xAA on the same edge -> reg[9]=0 afterwards, wr_count=0.
- Counter wrap with CNT_W=4: 17 valid writes to Rw=1..17 mod 31 -> wr_count=1; dbg_addr=17 returns the last busW written there one cycle later.
